// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: parses a length-prefixed, XOR-checksummed
// frame, emits one 32-bit imem write per four data bytes and releases the core only when the image checks out.
module imem_loader #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] word_cnt
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;

    state_t      state, state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [23:0] lane;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic        xfer;
    logic        restart;
    logic        len_big;

    assign xfer     = in_valid & in_ready;
    assign restart  = start & ((state == IDLE) | (state == DONE) | (state == ERROR));
    assign len_full = {in_data, len_lo};
    assign len_big  = {16'h0000, len_full} > $unsigned(DEPTH_WORDS);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = LEN0;
            LEN0: if (xfer) state_nxt = LEN1;
            LEN1: begin
                if (xfer) begin
                    if (len_big)              state_nxt = ERROR;
                    else if (len_full == '0)  state_nxt = CSUM;
                    else                      state_nxt = DATA;
                end
            end
            // The last byte of word N-1 moves on; its write lands during the first CSUM cycle.
            DATA: if (xfer && byte_idx == 2'd3 && (word_cnt + 16'd1) == len) state_nxt = CSUM;
            CSUM: if (xfer) state_nxt = (in_data == csum) ? DONE : ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        core_rst = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            LEN0, LEN1, DATA, CSUM: in_ready = 1'b1;
            DONE: begin
                core_rst = 1'b1;
                done     = 1'b1;
            end
            ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_lo   <= '0;
            len      <= '0;
            lane     <= '0;
            byte_idx <= '0;
            csum     <= '0;
            word_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                len_lo   <= '0;
                len      <= '0;
                lane     <= '0;
                byte_idx <= '0;
                csum     <= '0;
                word_cnt <= '0;
            end
            case (state)
                LEN0: if (xfer) len_lo <= in_data;
                LEN1: if (xfer) len <= len_full;
                DATA: begin
                    if (xfer) begin
                        // Lane shifts right so byte 0 ends up in bits 7:0 once byte 3 arrives.
                        lane     <= {in_data, lane[23:8]};
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_en    <= 1'b1;
                            wr_data  <= {in_data, lane};
                            wr_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                            word_cnt <= word_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed byte streams and checks writes, status and handshake.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_rst;
    logic        done;
    logic        error;
    logic [15:0] word_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int nwr = 0;
    logic [31:0] wa [8];
    logic [31:0] wd [8];

    imem_loader #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_rst(core_rst), .done(done), .error(error), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Log every write strobe mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            if (nwr < 8) begin
                wa[nwr] = wr_addr;
                wd[nwr] = wr_data;
            end
            nwr = nwr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int gap);
        foreach (q[i]) send(q[i], gap);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
        check({tag, "_wr_addr"},  wr_addr,           32'd0);
        check({tag, "_wr_data"},  wr_data,           32'd0);
        check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_error"},    {31'd0, error},    32'd0);
        check({tag, "_word_cnt"}, {16'd0, word_cnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // T1: reset
        step(); step();
        check_idle_outputs("t1");
        rst = 1'b1;
        step();
        check("t1_idle_ready", {31'd0, in_ready}, 32'd0);

        // T2: one word; checksum B3^E3^62^00 = 32
        nwr = 0;
        pulse_start();
        check("t2_len0_ready", {31'd0, in_ready}, 32'd1);
        check("t2_len0_corerst", {31'd0, core_rst}, 32'd0);
        send_seq('{8'h01, 8'h00, 8'hB3, 8'hE3, 8'h62}, 0);
        check("t2_no_early_wr", {31'd0, wr_en}, 32'd0);
        send(8'h00, 0);
        check("t2_wr_en", {31'd0, wr_en}, 32'd1);
        check("t2_wr_data", wr_data, 32'h0062E3B3);
        check("t2_wr_addr", wr_addr, 32'h0);
        check("t2_cnt_with_wr", {16'd0, word_cnt}, 32'd1);
        send(8'h32, 0);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_core_rst", {31'd0, core_rst}, 32'd1);
        check("t2_error", {31'd0, error}, 32'd0);
        check("t2_ready_low", {31'd0, in_ready}, 32'd0);
        check("t2_nwr", nwr, 32'd1);

        // T3: two words with stalls; checksum 33^F4^62^00^B3^E3^62^00 = 97
        nwr = 0;
        pulse_start();
        check("t3_cnt_cleared", {16'd0, word_cnt}, 32'd0);
        check("t3_done_cleared", {31'd0, done}, 32'd0);
        send_seq('{8'h02, 8'h00, 8'h33, 8'hF4, 8'h62, 8'h00,
                   8'hB3, 8'hE3, 8'h62, 8'h00, 8'h97}, 2);
        check("t3_nwr", nwr, 32'd2);
        check("t3_wd0", wd[0], 32'h0062F433);
        check("t3_wa0", wa[0], 32'h0);
        check("t3_wd1", wd[1], 32'h0062E3B3);
        check("t3_wa1", wa[1], 32'h4);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_word_cnt", {16'd0, word_cnt}, 32'd2);

        // T4: bad checksum, then recovery
        nwr = 0;
        pulse_start();
        send_seq('{8'h01, 8'h00, 8'hB3, 8'hE3, 8'h62, 8'h00, 8'h00}, 0);
        check("t4_error", {31'd0, error}, 32'd1);
        check("t4_core_rst", {31'd0, core_rst}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_nwr", nwr, 32'd1);
        check("t4_ready_low", {31'd0, in_ready}, 32'd0);
        pulse_start();
        check("t4_err_cleared", {31'd0, error}, 32'd0);
        send_seq('{8'h01, 8'h00, 8'hB3, 8'hE3, 8'h62, 8'h00, 8'h32}, 1);
        check("t4_retry_done", {31'd0, done}, 32'd1);
        check("t4_retry_error", {31'd0, error}, 32'd0);

        // T5: N = 0 and N = 1025
        nwr = 0;
        pulse_start();
        send_seq('{8'h00, 8'h00, 8'h00}, 0);
        check("t5_n0_done", {31'd0, done}, 32'd1);
        check("t5_n0_nwr", nwr, 32'd0);
        check("t5_n0_cnt", {16'd0, word_cnt}, 32'd0);
        pulse_start();
        send_seq('{8'h01, 8'h04}, 0);
        check("t5_big_error", {31'd0, error}, 32'd1);
        check("t5_big_ready", {31'd0, in_ready}, 32'd0);
        check("t5_big_nwr", nwr, 32'd0);

        // T6: reset mid-frame, then a clean load
        pulse_start();
        send_seq('{8'h01, 8'h00, 8'hB3, 8'hE3}, 0);
        rst = 1'b0;
        step();
        check_idle_outputs("t6");
        rst = 1'b1;
        nwr = 0;
        step(); step(); step();
        check("t6_no_wr", nwr, 32'd0);
        check("t6_still_idle", {31'd0, in_ready}, 32'd0);
        pulse_start();
        send_seq('{8'h01, 8'h00, 8'hB3, 8'hE3, 8'h62, 8'h00, 8'h32}, 0);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_nwr", nwr, 32'd1);
        check("t6_wd0", wd[0], 32'h0062E3B3);
        check("t6_wa0", wa[0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
